uart_rx_fifo: RTL and testbench

- Receive-side buffer directly downstream of the UART receiver.
- Captures each completed frame (rx_valid rising edge, 8-bit data, error flag) into a circular FIFO so a slower consumer can drain bytes with a read strobe.
- Reports occupancy, almost-full and a sticky overrun flag.
- Same clock domain as the UART core. No CDC inside.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_fifo_mem.sv | 42 ++++
 rtl/uart_rx_fifo.sv | 147 ++++++++++++++
 tb/tb_uart_rx_fifo.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and sizing constants.
// Contents:
//   UART_DATA_W        - width of one UART character
//   DEFAULT_FIFO_DEPTH - default byte depth for UART FIFOs
//   uart_byte_t        - one received/transmitted character
//   rx_entry_t         - stored receive entry: error tag plus data byte
package uart_pkg;

  localparam int UART_DATA_W        = 8;
  localparam int DEFAULT_FIFO_DEPTH = 16;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  typedef struct packed {
    logic       err;
    uart_byte_t data;
  } rx_entry_t;

endpackage

// File: rtl/uart_fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read.
// Intended to back both the RX and a future TX FIFO.
// Ports:
//   clk, rst             - clock; async active-high reset (read register only)
//   wr_en_i/wr_addr_i/wr_data_i - write port, commits on rising edge
//   rd_en_i/rd_addr_i    - read request; data appears on rd_data_o next cycle
//   rd_data_o            - registered read data, holds when rd_en_i is low
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W,
  parameter int DEPTH  = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Array contents are not reset; only the read register is.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
  end

  // Same-address write and read in one cycle returns the old entry,
  // which is what a full FIFO with a simultaneous read relies on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          rd_data_q <= '0;
    else if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive FIFO sitting directly behind the UART receiver.
// Each rising edge of rx_valid_in captures one frame into a circular buffer;
// the consumer pops bytes with rd_en (one-cycle read latency).
// Optional build macro: FRAME_ERR_STORE_EN
//   defined   - errored frames are stored with a tag, returned on rd_err
//   undefined - errored frames are dropped, rd_err is tied 0
// Ports:
//   clk, rst       - clock; async active-high reset
//   rx_valid_in    - frame complete (edge-detected)
//   rx_error_in    - frame error, sampled with the rx_valid_in rising edge
//   rx_data_in     - received byte, sampled with the rx_valid_in rising edge
//   rd_en          - pop request
//   rd_data/rd_err - popped byte and its error tag, valid with rd_valid
//   rd_valid       - one-cycle pulse after an accepted pop
//   empty/full/almost_full/count - occupancy status
//   overrun        - sticky: a frame was lost to a full FIFO
//   frame_err      - sticky: an errored frame was received
//   clr_flags      - clears overrun and frame_err (a same-cycle set wins)
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_FIFO_DEPTH,
  parameter int ADDR_W   = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid_in,
  input  logic             rx_error_in,
  input  uart_byte_t       rx_data_in,
  input  logic             rd_en,
  output uart_byte_t       rd_data,
  output logic             rd_valid,
  output logic             rd_err,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic [ADDR_W:0]  count,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_flags
);

  localparam int CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W:0] AF_CNT = CNT_W'(AF_LEVEL);

`ifdef FRAME_ERR_STORE_EN
  localparam int MEM_W = $bits(rx_entry_t);
`else
  localparam int MEM_W = UART_DATA_W;
`endif

  logic            rx_valid_q;
  logic [ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0] count_q, count_d;
  logic            rd_valid_q;
  logic            overrun_q, overrun_d;
  logic            frame_err_q, frame_err_d;

  logic             wr_evt, err_drop, wr_accept, rd_accept;
  logic [MEM_W-1:0] mem_wr_data, mem_rd_data;

  assign empty       = (wr_ptr_q == rd_ptr_q);
  assign full        = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                       (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
  assign almost_full = (count_q >= AF_CNT);
  assign count       = count_q;
  assign overrun     = overrun_q;
  assign frame_err   = frame_err_q;
  assign rd_valid    = rd_valid_q;

  assign wr_evt    = rx_valid_in & ~rx_valid_q;
  assign rd_accept = rd_en & ~empty;

`ifdef FRAME_ERR_STORE_EN
  rx_entry_t rd_entry;
  assign err_drop    = 1'b0;
  assign mem_wr_data = {rx_error_in, rx_data_in};
  assign rd_entry    = mem_rd_data;
  assign rd_data     = rd_entry.data;
  assign rd_err      = rd_entry.err;
`else
  assign err_drop    = wr_evt & rx_error_in;
  assign mem_wr_data = rx_data_in;
  assign rd_data     = mem_rd_data;
  assign rd_err      = 1'b0;
`endif

  // A full FIFO still takes the write when a pop frees a slot the same cycle.
  assign wr_accept = wr_evt & ~err_drop & (~full | rd_accept);

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    if (wr_accept) wr_ptr_d = wr_ptr_q + 1'b1;
    if (rd_accept) rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = wr_ptr_d - rd_ptr_d;
    if (clr_flags) begin
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end
    // Set events are applied after the clear so they take priority.
    if (wr_evt & ~err_drop & ~wr_accept) overrun_d   = 1'b1;
    if (wr_evt & rx_error_in)            frame_err_d = 1'b1;
  end

  // rx_valid_q resets high so a receiver already asserting valid
  // out of reset does not produce a phantom write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_valid_q  <= 1'b1;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      rx_valid_q  <= rx_valid_in;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_accept;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  uart_fifo_mem #(
    .DATA_W (MEM_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (wr_accept),
    .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
    .wr_data_i (mem_wr_data),
    .rd_en_i   (rd_accept),
    .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
    .rd_data_o (mem_rd_data)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
// Honours FRAME_ERR_STORE_EN the same way as the design.
module tb_uart_rx_fifo;

  localparam int DEPTH    = 16;
  localparam int AF_LEVEL = 12;
`ifdef FRAME_ERR_STORE_EN
  localparam bit STORE = 1'b1;
`else
  localparam bit STORE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid_in = 1'b0;
  logic       rx_error_in = 1'b0;
  logic [7:0] rx_data_in  = 8'h00;
  logic       rd_en       = 1'b0;
  logic       clr_flags   = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid, rd_err, empty, full, almost_full, overrun, frame_err;
  logic [4:0] count;

  int n_cmp = 0;
  int n_bad = 0;

  uart_rx_fifo dut (
    .clk         (clk),
    .rst         (rst),
    .rx_valid_in (rx_valid_in),
    .rx_error_in (rx_error_in),
    .rx_data_in  (rx_data_in),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_err      (rd_err),
    .empty       (empty),
    .full        (full),
    .almost_full (almost_full),
    .count       (count),
    .overrun     (overrun),
    .frame_err   (frame_err),
    .clr_flags   (clr_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of {err, data} entries.
  logic [8:0] mq[$];
  bit         m_prev = 1'b1;
  bit         m_ov = 1'b0, m_fe = 1'b0, m_rv = 1'b0, m_re = 1'b0;
  logic [7:0] m_rd = 8'h00;
  bit         evt, rd_ok, set_ov, set_fe;
  logic [8:0] ent;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_prev = 1'b1; m_ov = 1'b0; m_fe = 1'b0;
      m_rv = 1'b0; m_rd = 8'h00; m_re = 1'b0;
    end else begin
      evt    = rx_valid_in && !m_prev;
      m_prev = rx_valid_in;
      rd_ok  = rd_en && (mq.size() != 0);
      m_rv   = rd_ok;
      if (rd_ok) begin
        ent  = mq.pop_front();
        m_rd = ent[7:0];
        m_re = ent[8];
      end
      set_ov = 1'b0;
      set_fe = evt && rx_error_in;
      if (evt && (STORE || !rx_error_in)) begin
        if (mq.size() < DEPTH) mq.push_back({rx_error_in, rx_data_in});
        else set_ov = 1'b1;
      end
      if (clr_flags) begin m_ov = 1'b0; m_fe = 1'b0; end
      if (set_ov) m_ov = 1'b1;
      if (set_fe) m_fe = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("count",       count,       mq.size());
    chk("empty",       empty,       mq.size() == 0);
    chk("full",        full,        mq.size() == DEPTH);
    chk("almost_full", almost_full, mq.size() >= AF_LEVEL);
    chk("overrun",     overrun,     m_ov);
    chk("frame_err",   frame_err,   m_fe);
    chk("rd_valid",    rd_valid,    m_rv);
    chk("rd_data",     rd_data,     m_rd);
    chk("rd_err",      rd_err,      m_re);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [7:0] d, input logic e, input logic r);
    rx_data_in = d; rx_error_in = e; rx_valid_in = 1'b1; rd_en = r;
    tick();
    rx_valid_in = 1'b0; rx_error_in = 1'b0; rd_en = 1'b0;
    tick();
  endtask

  task automatic pulse_clr();
    clr_flags = 1'b1; tick(); clr_flags = 1'b0; tick();
  endtask

  initial begin
    // Reset
    repeat (3) tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("lit_reset_empty", empty, 1);
    chk("lit_reset_count", count, 0);

    // Single frame
    send(8'hA5, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_single_count", count, 1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    @(negedge clk);
    chk("lit_single_rdv",   rd_valid, 1);
    chk("lit_single_data",  rd_data, 8'hA5);
    chk("lit_single_empty", empty, 1);
    tick();

    // Fill, almost-full threshold, overrun
    for (int i = 0; i < 16; i++) begin
      send(8'(i), 1'b0, 1'b0);
      if (i == 10) begin @(negedge clk); chk("lit_af_at11", almost_full, 0); end
      if (i == 11) begin @(negedge clk); chk("lit_af_at12", almost_full, 1); end
    end
    @(negedge clk);
    chk("lit_full", full, 1);
    send(8'h10, 1'b0, 1'b0);
    @(negedge clk);
    chk("lit_overrun", overrun, 1);
    chk("lit_ovr_count", count, 16);
    pulse_clr();
    @(negedge clk);
    chk("lit_clr_overrun", overrun, 0);

    // Full FIFO: write and read in the same cycle
    send(8'h55, 1'b0, 1'b1);
    @(negedge clk);
    chk("lit_simul_count", count, 16);
    chk("lit_simul_ovr",   overrun, 0);
    rd_en = 1'b1;
    repeat (16) tick();
    rd_en = 1'b0;
    @(negedge clk);
    chk("lit_drain_last",  rd_data, 8'h55);
    chk("lit_drain_empty", empty, 1);
    tick();

    // Error frame
    send(8'h3C, 1'b1, 1'b0);
    @(negedge clk);
    chk("lit_fe_flag", frame_err, 1);
`ifdef FRAME_ERR_STORE_EN
    chk("lit_fe_count", count, 1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    @(negedge clk);
    chk("lit_fe_data", rd_data, 8'h3C);
    chk("lit_fe_tag",  rd_err, 1);
    tick();
`else
    chk("lit_fe_count", count, 0);
`endif
    pulse_clr();

    // Read while empty: no pulse, data holds
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    @(negedge clk);
    chk("lit_empty_rdv", rd_valid, 0);
    chk("lit_empty_hold", rd_data, STORE ? 8'h3C : 8'h55);
    tick();

    // Streaming with interleaved reads, forcing pointer wrap
    for (int i = 0; i < 40; i++) send(8'((i * 37 + 5) & 8'hFF), 1'b0, (i % 3) != 0);
    rd_en = 1'b1;
    repeat (20) tick();
    rd_en = 1'b0;
    tick();
    @(negedge clk);
    chk("lit_stream_empty", empty, 1);
    chk("lit_stream_ovr", overrun, 0);

    // Reset mid-read with rx_valid held high
    send(8'h11, 1'b0, 1'b0);
    send(8'h22, 1'b0, 1'b0);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    rx_data_in = 8'h77; rx_valid_in = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("lit_rst_count",   count, 0);
    chk("lit_rst_empty",   empty, 1);
    chk("lit_rst_rdv",     rd_valid, 0);
    chk("lit_rst_rd_data", rd_data, 0);
    tick(); tick();
    rst = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    chk("lit_rst_nowrite", count, 0);
    rx_valid_in = 1'b0; tick();
    rx_valid_in = 1'b1; tick();
    rx_valid_in = 1'b0;
    @(negedge clk);
    chk("lit_rst_rewrite", count, 1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
